// File: rtl/reg_file_pkg.sv
// Shared defaults and types for the architectural register file with busy scoreboard.
package reg_file_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int DEPTH_DEF  = 32;
  localparam int NUM_RD_DEF = 2;

  typedef logic [XLEN_DEF-1:0]          word_t;
  typedef logic [$clog2(DEPTH_DEF)-1:0] reg_addr_t;

endpackage

// File: rtl/reg_file_scoreboard.sv
// Per-register busy scoreboard: issue-time reservation, writeback clear, per-port lookup.
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter  int DEPTH  = DEPTH_DEF,
  parameter  int NUM_RD = NUM_RD_DEF,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wr_en_i,
  input  logic [AW-1:0]        wr_addr_i,
  input  logic                 rsv_en_i,
  input  logic [AW-1:0]        rsv_addr_i,
  input  logic [NUM_RD*AW-1:0] rd_addr_i,
  output logic                 rsv_ready_o,
  output logic [DEPTH-1:0]     busy_vec_o,
  output logic [NUM_RD-1:0]    rd_busy_o
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  assign rsv_ready_o = ~busy_q[rsv_addr_i] | (rsv_addr_i == '0);
  assign busy_vec_o  = busy_q;

  // Clear first, then set, so a reservation landing with a writeback on the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_i && (wr_addr_i != '0)) begin
      busy_d[wr_addr_i] = 1'b0;
    end
    if (rsv_en_i && rsv_ready_o && (rsv_addr_i != '0)) begin
      busy_d[rsv_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_comb begin
    rd_busy_o = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_busy_o[k] = busy_q[rd_addr_i[k*AW +: AW]];
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// DEPTH x XLEN register file, NUM_RD async read ports, one write port, zero register and busy scoreboard.
// Optional write-to-read bypass enabled by defining REG_FILE_SB_BYPASS_EN.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter  int XLEN   = XLEN_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  parameter  int NUM_RD = NUM_RD_DEF,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_RD*AW-1:0]   rd_addr_i,
  output logic [NUM_RD*XLEN-1:0] rd_data_ao,
  output logic [NUM_RD-1:0]      rd_busy_ao,
  input  logic                   wr_en_i,
  input  logic [AW-1:0]          wr_addr_i,
  input  logic [XLEN-1:0]        wr_data_i,
  input  logic                   rsv_en_i,
  input  logic [AW-1:0]          rsv_addr_i,
  output logic                   rsv_ready_o,
  output logic [DEPTH-1:0]       busy_vec_o
);

  logic [XLEN-1:0]   rf_q [DEPTH];
  logic [XLEN-1:0]   rf_d [DEPTH];
  logic [NUM_RD-1:0] sb_busy;

  reg_file_scoreboard #(
    .DEPTH  (DEPTH),
    .NUM_RD (NUM_RD)
  ) u_scoreboard (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .wr_en_i     (wr_en_i),
    .wr_addr_i   (wr_addr_i),
    .rsv_en_i    (rsv_en_i),
    .rsv_addr_i  (rsv_addr_i),
    .rd_addr_i   (rd_addr_i),
    .rsv_ready_o (rsv_ready_o),
    .busy_vec_o  (busy_vec_o),
    .rd_busy_o   (sb_busy)
  );

  // Register 0 is never written, so it holds its reset value of zero forever.
  always_comb begin
    rf_d = rf_q;
    if (wr_en_i && (wr_addr_i != '0)) begin
      rf_d[wr_addr_i] = wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      rf_q <= rf_d;
    end
  end

  always_comb begin
    rd_data_ao = '0;
    rd_busy_ao = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_data_ao[k*XLEN +: XLEN] = rf_q[rd_addr_i[k*AW +: AW]];
      rd_busy_ao[k]              = sb_busy[k];
`ifdef REG_FILE_SB_BYPASS_EN
      // Forward the writeback in flight; gated by reset so outputs stay zero while held.
      if (rst_ni && wr_en_i && (wr_addr_i != '0) && (wr_addr_i == rd_addr_i[k*AW +: AW])) begin
        rd_data_ao[k*XLEN +: XLEN] = wr_data_i;
        rd_busy_ao[k]              = 1'b0;
      end
`endif
    end
  end

endmodule
